// File: rtl/cpu_pkg.sv
// Shared RV64 pipeline definitions: widths, NOP encoding, fetch FSM states,
// and the instruction-buffer entry type.
package cpu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc,instr} buffer between fetch and decode. Flush wins over
// push/pop; a push into a full buffer is accepted when a pop happens alongside.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic          push_ok_s, pop_ok_s;

  // Pointer, count and storage update
  always_comb begin
    pop_ok_s  = pop && (count_q != CW'(0));
    push_ok_s = push && ((count_q != CW'(DEPTH)) || pop_ok_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));

endmodule

// File: rtl/instr_fetch_unit.sv
// RV64 fetch stage: PC + request FSM, one outstanding imem read, buffered
// output to decode. Optional counters under `FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            req_fire_s, fifo_push_s, fifo_pop_s, post_push_slot_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [CW-1:0]   fifo_count_s;
  fetch_entry_t    push_entry_s, fifo_head_s;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push_s),
    .push_entry (push_entry_s),
    .pop        (fifo_pop_s),
    .flush      (redirect_valid),
    .head       (fifo_head_s),
    .count      (fifo_count_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  // FSM and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next state, PC update and FIFO push/pop control
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    req_pc_d           = req_pc_q;
    fifo_push_s        = 1'b0;
    req_fire_s         = (state_q == S_REQ) && imem_req_ready;
    fifo_pop_s         = !fifo_empty_s && if_ready && !redirect_valid;
    // The pushing response always had a slot reserved, so a pop frees one for sure.
    post_push_slot_s   = fifo_pop_s || (fifo_count_s < CW'(FIFO_DEPTH - 1));
    push_entry_s.pc    = req_pc_q;
    push_entry_s.instr = imem_rsp_data;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid || !fifo_full_s) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (req_fire_s) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          state_d  = redirect_valid ? S_DROP : S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_valid) begin
            state_d = S_REQ;
          end else begin
            fifo_push_s = 1'b1;
            state_d     = post_push_slot_s ? S_REQ : S_IDLE;
          end
        end else begin
          state_d = redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else begin
      pc_d = pc_d;
    end
  end

  // Interface outputs decoded from registered state and FIFO head
  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;
    if_valid       = !fifo_empty_s;
    if (fifo_empty_s) begin
      if_instr = NOP_INSTR;
      if_pc    = 64'd0;
    end else begin
      if_instr = fifo_head_s.instr;
      if_pc    = fifo_head_s.pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

  // Performance counter increments
  always_comb begin
    perf_fetched_d = perf_fetched_q + (fifo_push_s ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q + ((if_ready && fifo_empty_s) ? 32'd1 : 32'd0);
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
